// File: rtl/d_mem_arbiter.sv
// ---------------------------------------------------------------------------
// d_mem_arbiter
//
// Two-port arbiter and sequencer in front of the 16-bit-word, byte-addressed
// data memory. Port 0 is the pipeline MEM stage, port 1 the debug/loader
// port. Each accepted request takes one ACCESS cycle on the memory bus and
// one RESP cycle in which the owner receives its completion pulse.
// Port 0 has fixed priority. Port 1 is forced through after STARVE_LIMIT
// consecutive lost arbitrations.
//
// Ports
//   clk                    system clock, rising edge
//   reset                  asynchronous, active-low reset
//   pN_req/we/addr/wdata   request from port N (held stable until pN_gnt)
//   pN_gnt                 request accepted this cycle (combinational)
//   pN_rsp_valid           one-cycle completion pulse
//   pN_rdata / pN_err      read data / out-of-range flag, valid with rsp
//   d_mem_addr             memory byte address (holds between accesses)
//   d_mem_opertn, wr_rd    memory operation enable / 1 = write
//   d_mem_wr_data_l/h      write bytes for addr / addr+1 (zero when idle)
//   d_mem_rd_data_l/h      registered read bytes from the memory
//   busy                   arbiter is not idle
// ---------------------------------------------------------------------------
module d_mem_arbiter #(
    parameter int MEM_BYTES    = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [15:0] p0_addr,
    input  logic [15:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rsp_valid,
    output logic [15:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [15:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rsp_valid,
    output logic [15:0] p1_rdata,
    output logic        p1_err,
    output logic [15:0] d_mem_addr,
    output logic        d_mem_opertn,
    output logic        wr_rd,
    output logic [7:0]  d_mem_wr_data_l,
    output logic [7:0]  d_mem_wr_data_h,
    input  logic [7:0]  d_mem_rd_data_l,
    input  logic [7:0]  d_mem_rd_data_h,
    output logic        busy
);

    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_ACCESS  = 2'd1;
    localparam logic [1:0]  ST_RESP    = 2'd2;
    // Highest legal low-byte address: the access also touches addr+1.
    localparam logic [15:0] ADDR_LAST  = 16'(MEM_BYTES - 2);
    localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);

    function automatic logic [3:0] starve_sat_inc(input logic [3:0] cnt);
        logic [3:0] nxt;
        if (cnt >= STARVE_MAX) begin
            nxt = STARVE_MAX;
        end else begin
            nxt = cnt + 4'd1;
        end
        return nxt;
    endfunction

    logic [1:0]  state;
    logic [3:0]  starve_cnt;
    logic        owner_p1;
    logic [15:0] mem_addr_lat;
    logic        we_lat;
    logic [15:0] wdata_lat;
    logic        err_lat;

    logic        arb_slot;
    logic        p1_wins;
    logic        any_gnt;
    logic [15:0] sel_addr;
    logic        in_access;
    logic        in_resp;
    logic        access_ok;
    logic        read_ok;

    // Arbitration happens in IDLE and RESP. Gating with reset keeps both
    // grants low while reset is asserted.
    assign arb_slot = reset && ((state == ST_IDLE) || (state == ST_RESP));
    assign p1_wins  = p1_req && (!p0_req || (starve_cnt == STARVE_MAX));
    assign p1_gnt   = arb_slot && p1_wins;
    assign p0_gnt   = arb_slot && p0_req && !p1_wins;
    assign any_gnt  = p0_gnt || p1_gnt;
    assign sel_addr = p1_gnt ? p1_addr : p0_addr;

    // Grant -> ACCESS boundary: control state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            starve_cnt   <= 4'd0;
            owner_p1     <= 1'b0;
            mem_addr_lat <= 16'd0;
        end else begin
            case (state)
                ST_IDLE, ST_RESP: state <= any_gnt ? ST_ACCESS : ST_IDLE;
                ST_ACCESS:        state <= ST_RESP;
                default:          state <= ST_IDLE;
            endcase

            if (arb_slot) begin
                if (!p1_req || p1_gnt) begin
                    starve_cnt <= 4'd0;
                end else begin
                    starve_cnt <= starve_sat_inc(starve_cnt);
                end
            end

            if (any_gnt) begin
                owner_p1 <= p1_gnt;
                // Out-of-range requests never reach the bus, so the bus
                // address keeps its previous value for them.
                if (sel_addr <= ADDR_LAST) begin
                    mem_addr_lat <= sel_addr;
                end
            end
        end
    end

    // Grant -> ACCESS boundary: request payload
    always_ff @(posedge clk) begin
        if (any_gnt) begin
            we_lat    <= p1_gnt ? p1_we : p0_we;
            wdata_lat <= p1_gnt ? p1_wdata : p0_wdata;
            err_lat   <= (sel_addr > ADDR_LAST);
        end
    end

    // ACCESS: memory bus drive
    assign in_access       = (state == ST_ACCESS);
    assign access_ok       = in_access && !err_lat;
    assign d_mem_opertn    = access_ok;
    assign wr_rd           = access_ok && we_lat;
    assign d_mem_addr      = mem_addr_lat;
    assign d_mem_wr_data_l = access_ok ? wdata_lat[7:0]  : 8'd0;
    assign d_mem_wr_data_h = access_ok ? wdata_lat[15:8] : 8'd0;

    // RESP: completion to the owner
    assign in_resp      = (state == ST_RESP);
    assign read_ok      = !we_lat && !err_lat;
    assign p0_rsp_valid = in_resp && !owner_p1;
    assign p1_rsp_valid = in_resp && owner_p1;
    assign p0_rdata     = (p0_rsp_valid && read_ok) ? {d_mem_rd_data_h, d_mem_rd_data_l} : 16'd0;
    assign p1_rdata     = (p1_rsp_valid && read_ok) ? {d_mem_rd_data_h, d_mem_rd_data_l} : 16'd0;
    assign p0_err       = p0_rsp_valid && err_lat;
    assign p1_err       = p1_rsp_valid && err_lat;

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_d_mem_arbiter.sv
module tb_d_mem_arbiter;

    localparam int MEM_BYTES    = 128;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        p0_req = 1'b0;
    logic        p0_we = 1'b0;
    logic [15:0] p0_addr = 16'd0;
    logic [15:0] p0_wdata = 16'd0;
    logic        p1_req = 1'b0;
    logic        p1_we = 1'b0;
    logic [15:0] p1_addr = 16'd0;
    logic [15:0] p1_wdata = 16'd0;
    logic        p0_gnt, p0_rsp_valid, p0_err;
    logic [15:0] p0_rdata;
    logic        p1_gnt, p1_rsp_valid, p1_err;
    logic [15:0] p1_rdata;
    logic [15:0] d_mem_addr;
    logic        d_mem_opertn, wr_rd, busy;
    logic [7:0]  wr_l, wr_h;
    logic [7:0]  rd_l = 8'd0;
    logic [7:0]  rd_h = 8'd0;

    always #5 clk = ~clk;

    d_mem_arbiter #(.MEM_BYTES(MEM_BYTES), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rsp_valid(p0_rsp_valid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rsp_valid(p1_rsp_valid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .d_mem_addr(d_mem_addr), .d_mem_opertn(d_mem_opertn), .wr_rd(wr_rd),
        .d_mem_wr_data_l(wr_l), .d_mem_wr_data_h(wr_h),
        .d_mem_rd_data_l(rd_l), .d_mem_rd_data_h(rd_h), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Data memory: registered reads, write-through of write data when idle.
    logic [7:0] init_img [MEM_BYTES];
    logic [7:0] env_mem  [MEM_BYTES];
    bit env_loaded = 1'b0;

    always @(posedge clk) begin
        if (!env_loaded) begin
            for (int i = 0; i < MEM_BYTES; i++) env_mem[i] <= init_img[i];
            env_loaded <= 1'b1;
        end else if (d_mem_opertn) begin
            if (wr_rd) begin
                env_mem[d_mem_addr[6:0]]         <= wr_l;
                env_mem[d_mem_addr[6:0] + 7'd1]  <= wr_h;
            end else begin
                rd_l <= env_mem[d_mem_addr[6:0]];
                rd_h <= env_mem[d_mem_addr[6:0] + 7'd1];
            end
        end else begin
            rd_l <= wr_l;
            rd_h <= wr_h;
        end
    end

    // Reference model: one outstanding transaction, access one cycle after
    // its grant, response two cycles after it.
    typedef struct {
        int          port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } txn_t;

    txn_t        cur = '{port: 0, we: 1'b0, addr: 16'd0, wdata: 16'd0, rdata: 16'd0};
    logic [7:0]  ref_mem [MEM_BYTES];
    bit          ref_loaded = 1'b0;
    int          cyc = 0;
    int          last_gnt = -10;
    int          starve = 0;
    logic [15:0] exp_addr = 16'd0;
    int          gnt_log[$];

    always @(negedge clk) begin : model
        bit          acc, rsp, good, e_op, e_wr, e_v0, e_v1, e_e0, e_e1;
        logic [7:0]  e_wl, e_wh;
        logic [15:0] e_rd0, e_rd1;
        int          win, ia;
        if (!ref_loaded) begin
            for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_img[i];
            ref_loaded = 1'b1;
        end
        if (!reset) begin
            cyc = 0;
            last_gnt = -10;
            starve = 0;
            exp_addr = 16'd0;
        end else begin
            cyc++;
            acc  = (last_gnt == cyc - 1);
            rsp  = (last_gnt == cyc - 2);
            good = (cur.addr <= 16'(MEM_BYTES - 2));
            ia   = int'(cur.addr);
            e_op = 1'b0; e_wr = 1'b0; e_wl = 8'd0; e_wh = 8'd0;
            if (acc && good) begin
                e_op = 1'b1;
                e_wr = cur.we;
                e_wl = cur.wdata[7:0];
                e_wh = cur.wdata[15:8];
                exp_addr = cur.addr;
                if (cur.we) begin
                    ref_mem[ia]     = cur.wdata[7:0];
                    ref_mem[ia + 1] = cur.wdata[15:8];
                end else begin
                    cur.rdata = {ref_mem[ia + 1], ref_mem[ia]};
                end
            end
            check_val("opertn", 32'(d_mem_opertn), 32'(e_op));
            check_val("wr_rd", 32'(wr_rd), 32'(e_wr));
            check_val("wr_data_l", 32'(wr_l), 32'(e_wl));
            check_val("wr_data_h", 32'(wr_h), 32'(e_wh));
            check_val("mem_addr", 32'(d_mem_addr), 32'(exp_addr));

            e_v0  = rsp && (cur.port == 0);
            e_v1  = rsp && (cur.port == 1);
            e_rd0 = e_v0 ? cur.rdata : 16'd0;
            e_rd1 = e_v1 ? cur.rdata : 16'd0;
            e_e0  = e_v0 && !good;
            e_e1  = e_v1 && !good;
            check_val("p0_rsp_valid", 32'(p0_rsp_valid), 32'(e_v0));
            check_val("p1_rsp_valid", 32'(p1_rsp_valid), 32'(e_v1));
            check_val("p0_rdata", 32'(p0_rdata), 32'(e_rd0));
            check_val("p1_rdata", 32'(p1_rdata), 32'(e_rd1));
            check_val("p0_err", 32'(p0_err), 32'(e_e0));
            check_val("p1_err", 32'(p1_err), 32'(e_e1));
            check_val("busy", 32'(busy), 32'(acc || rsp));

            win = -1;
            if (!acc) begin
                if (p1_req && (!p0_req || starve == STARVE_LIMIT)) win = 1;
                else if (p0_req) win = 0;
                if (!p1_req || win == 1) starve = 0;
                else if (starve < STARVE_LIMIT) starve++;
            end
            check_val("p0_gnt", 32'(p0_gnt), 32'(win == 0));
            check_val("p1_gnt", 32'(p1_gnt), 32'(win == 1));
            check_val("one_gnt", 32'(p0_gnt & p1_gnt), 32'd0);
            if (win >= 0) begin
                last_gnt  = cyc;
                gnt_log.push_back(win);
                cur.port  = win;
                cur.we    = (win == 1) ? p1_we : p0_we;
                cur.addr  = (win == 1) ? p1_addr : p0_addr;
                cur.wdata = (win == 1) ? p1_wdata : p0_wdata;
                cur.rdata = 16'd0;
            end
        end
    end

    // Requester side
    bit g0, g1;

    task automatic tick();
        @(negedge clk);
        g0 = p0_gnt;
        g1 = p1_gnt;
        @(posedge clk);
        #1;
        if (g0) p0_req = 1'b0;
        if (g1) p1_req = 1'b0;
    endtask

    task automatic issue(input int port, input logic we, input logic [15:0] a, input logic [15:0] d);
        if (port == 1) begin
            p1_we = we; p1_addr = a; p1_wdata = d; p1_req = 1'b1;
        end else begin
            p0_we = we; p0_addr = a; p0_wdata = d; p0_req = 1'b1;
        end
    endtask

    task automatic wait_gnt(input int port);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            tick();
            n++;
            got = (port == 1) ? g1 : g0;
        end
        check_val("gnt_wait", 32'(got), 32'd1);
    endtask

    task automatic rand_port(input int port, input int pct);
        logic        we;
        logic [15:0] a;
        logic [15:0] d;
        bit          pending;
        pending = (port == 1) ? p1_req : p0_req;
        if (!pending) begin
            if ($urandom_range(0, 99) < pct) begin
                we = 1'($urandom_range(0, 1));
                a  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(127, 65535))
                                                : 16'($urandom_range(0, 126));
                d  = 16'($urandom);
                issue(port, we, a, d);
            end
        end else if ($urandom_range(0, 99) < 3) begin
            if (port == 1) p1_req = 1'b0;
            else p0_req = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_order [6];
        exp_order = '{0, 0, 0, 0, 1, 0};
        for (int i = 0; i < MEM_BYTES; i++) init_img[i] = 8'($urandom);
        init_img[0] = 8'h06;
        init_img[1] = 8'h00;
        init_img[2] = 8'h01;
        init_img[3] = 8'h40;

        // Reset values, with a request pending to show gnt is suppressed
        reset = 1'b0;
        p0_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_p0_gnt", 32'(p0_gnt), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_opertn", 32'(d_mem_opertn), 32'd0);
        check_val("rst_addr", 32'(d_mem_addr), 32'd0);
        check_val("rst_p0_rsp", 32'(p0_rsp_valid), 32'd0);
        p0_req = 1'b0;
        reset = 1'b1;

        // Basic read of address 0
        issue(0, 1'b0, 16'd0, 16'd0);
        wait_gnt(0);
        check_val("rd0_access_op", 32'(d_mem_opertn), 32'd1);
        check_val("rd0_access_wr", 32'(wr_rd), 32'd0);
        tick();
        check_val("rd0_rsp", 32'(p0_rsp_valid), 32'd1);
        check_val("rd0_rdata", 32'(p0_rdata), 32'h0006);
        check_val("rd0_err", 32'(p0_err), 32'd0);
        tick();

        // Port 1 write then read back
        issue(1, 1'b1, 16'd20, 16'hBEEF);
        wait_gnt(1);
        check_val("wr_l", 32'(wr_l), 32'h00EF);
        check_val("wr_h", 32'(wr_h), 32'h00BE);
        check_val("wr_we", 32'(wr_rd), 32'd1);
        tick();
        tick();
        issue(1, 1'b0, 16'd20, 16'd0);
        wait_gnt(1);
        tick();
        check_val("rd20_rdata", 32'(p1_rdata), 32'h0000BEEF);
        tick();

        // Both ports held requesting
        gnt_log.delete();
        issue(0, 1'b0, 16'd4, 16'd0);
        issue(1, 1'b0, 16'd6, 16'd0);
        repeat (14) @(posedge clk);
        #1;
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (3) tick();
        if (gnt_log.size() < 6) begin
            check_val("starve_count", 32'(gnt_log.size()), 32'd6);
        end else begin
            for (int i = 0; i < 6; i++) check_val("starve_order", 32'(gnt_log[i]), 32'(exp_order[i]));
        end

        // Out-of-range addresses
        issue(0, 1'b0, 16'd127, 16'd0);
        wait_gnt(0);
        check_val("oor127_op", 32'(d_mem_opertn), 32'd0);
        tick();
        check_val("oor127_err", 32'(p0_err), 32'd1);
        check_val("oor127_rdata", 32'(p0_rdata), 32'd0);
        tick();
        issue(0, 1'b0, 16'h8000, 16'd0);
        wait_gnt(0);
        check_val("oor8000_op", 32'(d_mem_opertn), 32'd0);
        tick();
        check_val("oor8000_err", 32'(p0_err), 32'd1);
        tick();

        // Back-to-back: re-request in own RESP cycle
        issue(0, 1'b0, 16'd0, 16'd0);
        wait_gnt(0);
        tick();
        issue(0, 1'b0, 16'd2, 16'd0);
        tick();
        check_val("b2b_gnt", 32'(g0), 32'd1);
        check_val("b2b_op", 32'(d_mem_opertn), 32'd1);
        check_val("b2b_addr", 32'(d_mem_addr), 32'd2);
        tick();
        check_val("b2b_rdata", 32'(p0_rdata), 32'h4001);
        tick();

        // Reset during ACCESS of a port 1 read
        issue(1, 1'b0, 16'd10, 16'd0);
        wait_gnt(1);
        reset = 1'b0;
        #1;
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_op", 32'(d_mem_opertn), 32'd0);
        check_val("mid_rst_addr", 32'(d_mem_addr), 32'd0);
        check_val("mid_rst_p1_rsp", 32'(p1_rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        check_val("post_rst_busy", 32'(busy), 32'd0);
        check_val("post_rst_p1_rsp", 32'(p1_rsp_valid), 32'd0);
        issue(0, 1'b0, 16'd0, 16'd0);
        wait_gnt(0);
        tick();
        check_val("post_rst_rdata", 32'(p0_rdata), 32'h0006);
        tick();

        // Randomized traffic against the model
        repeat (1500) begin
            tick();
            rand_port(0, 45);
            rand_port(1, 35);
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/d_mem_arbiter.md
Name: d_mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 16-bit-word, byte-addressed data memory.
- Port 0 serves the pipeline MEM stage; port 1 serves the debug/loader port.
- Accepts one request per arbitration slot, drives the memory's operation/read-write/address/data controls for one access cycle, then returns the registered read data or write completion to the owner.
- Applies fixed priority to port 0 with a starvation guard for port 1, and rejects out-of-range addresses.

Parameters:
- MEM_BYTES, 128: byte depth of the data memory. An access uses bytes addr and addr+1.
- STARVE_LIMIT, 4: consecutive lost arbitrations by a requesting port 1 before port 1 is forced to win. Range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- p0_req  input  1  port 0 request; hold with fields stable until p0_gnt
- p0_we  input  1  1 = write, 0 = read
- p0_addr  input  16  byte address of low byte
- p0_wdata  input  16  write data; [7:0] goes to addr, [15:8] to addr+1
- p0_gnt  output  1  request accepted this cycle (combinational)
- p0_rsp_valid  output  1  one-cycle completion pulse
- p0_rdata  output  16  read data, valid with p0_rsp_valid (0 for writes and errors)
- p0_err  output  1  address out of range, valid with p0_rsp_valid
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rsp_valid, p1_rdata, p1_err: same as port 0, for port 1
- d_mem_addr  output  16  memory byte address
- d_mem_opertn  output  1  memory operation enable
- wr_rd  output  1  1 = write, 0 = read
- d_mem_wr_data_l  output  8  write byte to addr
- d_mem_wr_data_h  output  8  write byte to addr+1
- d_mem_rd_data_l  input  8  registered read byte from addr
- d_mem_rd_data_h  input  8  registered read byte from addr+1
- busy  output  1  state is not IDLE

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Arbitration occurs only in IDLE and RESP, and only when a req is high.
  - The winner's gnt is asserted that cycle.
  - we/addr/wdata/port-id are latched at the clock edge.
  - Next state is ACCESS.
  - With no req: RESP goes to IDLE and IDLE stays IDLE.
- Priority: port 0 wins unless starve_cnt == STARVE_LIMIT and p1_req is high, in which case port 1 wins.
- starve_cnt (4-bit):
  - increments when p1_req is high and port 1 loses an arbitration;
  - clears on any p1 grant, or when p1_req is low in an arbitration cycle;
  - saturates at STARVE_LIMIT.
- ACCESS (exactly one cycle), for a latched address with addr <= MEM_BYTES-2:
  - d_mem_opertn = 1;
  - wr_rd = latched we;
  - d_mem_addr = latched addr;
  - wr_data_l/h = latched wdata[7:0]/[15:8].
- ACCESS for addr > MEM_BYTES-2 (including any upper address bits set):
  - d_mem_opertn = 0 and no memory access is made;
  - the error flag is latched.
- ACCESS always transitions to RESP.
- RESP (one cycle):
  - owner's rsp_valid = 1;
  - rdata = {d_mem_rd_data_h, d_mem_rd_data_l} for a good read, otherwise 0;
  - err = latched error flag;
  - the other port's rsp outputs are 0.
- Latency: gnt in cycle N, memory access in N+1, rsp_valid in N+2. Peak throughput is one access per 2 cycles (back-to-back via RESP→ACCESS).
- Outside ACCESS:
  - d_mem_opertn = 0 and wr_rd = 0;
  - d_mem_addr holds its last value;
  - wr_data_l/h = 0 (the memory passes write data to its read outputs when idle, so zeros keep the read bus clean).
- Reset values of every output: gnt 0, rsp_valid 0, rdata 0, err 0, d_mem_addr 0, d_mem_opertn 0, wr_rd 0, wr_data 0, busy 0.
- Reset asserted mid-transaction: the transaction is abandoned, no rsp_valid is issued, starve_cnt clears, and the FSM returns to IDLE. A write in ACCESS may or may not land.
- Simultaneous p0_req and p1_req: only one gnt is ever high in a cycle. The loser must keep req high.
- A req that drops before gnt is ignored and no response is produced.
- A requester may re-request in its own RESP cycle.

Test Plan:
- Memory initialised with byte0=0x06, byte1=0x00, byte2=0x01, byte3=0x40. p0 reads addr 0 → p0_gnt cycle N, d_mem_opertn=1 with wr_rd=0 in N+1, p0_rsp_valid in N+2 with p0_rdata=0x0006 and err=0.
- p1 writes 0xBEEF to addr 20, then p1 reads addr 20 → wr_data_l=0xEF and wr_data_h=0xBE during ACCESS; the read returns p1_rdata=0xBEEF.
- p0_req and p1_req held continuously with STARVE_LIMIT=4 → grant order p0,p0,p0,p0,p1,p0,... and only one gnt per cycle.
- p0 reads addr 127 (MEM_BYTES-1), then addr 0x8000 → d_mem_opertn stays 0; p0_rsp_valid with p0_err=1 and p0_rdata=0.
- Back-to-back: p0 re-requests (read addr 2) in its RESP cycle → gnt in the RESP cycle, next ACCESS immediately; rdata=0x4001 two cycles later.
- reset driven low during ACCESS of a p1 read → all outputs 0 immediately; after release, busy=0, no p1_rsp_valid, and a new p0 read completes normally.
